fifo2spi_arb: RTL and testbench
===============================

Name: fifo2spi_arb

Overview:
Parametrised next-generation request decoder between the AXI-side request/data/response FIFOs and the SPI-side register file, TX FIFO and RX FIFO.
- Adds fair round-robin arbitration between the read and write paths.
- Applies byte strobes: read-modify-write on registers, strobes passed through to TX.
- Bounded wait on TX-full / RX-empty before returning SLVERR.
- Start-pulse generation with busy tracking and collision flagging.

Parameters:
DATA_W, 32, register/FIFO data width (multiple of 8)
STRB_W, DATA_W/8, byte-strobe width
START_BIT, 13, bit of reg_trans_ctrl_i whose rising edge starts a transfer
TX_WAIT, 16, max cycles to wait for TX space (0 = immediate SLVERR)
RX_WAIT, 16, max cycles to wait for RX data (0 = immediate SLVERR)

Ports:
clk_i  in  1  system clock
reset_n_i  in  1  asynchronous active-low reset
reg_control_i / reg_trans_ctrl_i / reg_status_i  in  DATA_W each  current register values
reg_data_o  out  DATA_W  merged register write data
reg_load_o  out  1  register load pulse
reg_sel_o  out  2  register select (0 ctrl, 1 trans_ctrl)
wr_req_empty_i / wr_data_empty_i  in  1  write FIFOs empty
wr_req_data_i  in  2  write select
wr_data_data_i  in  DATA_W+STRB_W  {data, strb}
wr_req_pull_o / wr_data_pull_o  out  1  pop pulses
wr_resp_full_i  in  1 ; wr_resp_data_o  out  2 ; wr_resp_push_o  out  1
rd_req_empty_i  in  1 ; rd_req_data_i  in  2 ; rd_req_pull_o  out  1
rd_resp_full_i  in  1 ; rd_resp_data_o  out  DATA_W+2  {data, resp} ; rd_resp_push_o  out  1
tx_full_i  in  1 ; tx_data_o  out  DATA_W ; tx_strb_o  out  STRB_W ; tx_push_o  out  1
rx_empty_i  in  1 ; rx_data_i  in  DATA_W ; rx_pull_o  out  1
trans_done_i  in  1 ; trans_start_o  out  1 ; spi_busy_o  out  1 ; start_err_o  out  1

Behaviour:
- Reset: reset_n_i is asynchronous, active-low; clock is clk_i.
  - All outputs reset to 0.
  - State resets to IDLE, wait counter to 0, last_grant to READ.
  - Reset mid-transaction abandons it; no response is pushed.
- FIFOs are show-ahead. All outputs are registered. Every pull/push/load is a single-cycle pulse.
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- IDLE: write is pending when !wr_req_empty_i & !wr_data_empty_i; read is pending when !rd_req_empty_i.
  - Both pending: grant the path opposite last_grant. Otherwise grant the pending path.
  - Update last_grant on grant.
  - On grant, capture sel/data/strb into hold registers and pulse the matching pulls in the next cycle → WR_EXEC or RD_EXEC.
- WR_EXEC (1 cycle):
  - sel 0/1: reg_data_o = bytewise (strb ? wdata : current reg); reg_sel_o = sel; reg_load_o pulses only if strb != 0; resp OKAY.
  - sel 2 (status, RO): no load; SLVERR.
  - sel 3: if !tx_full_i, pulse tx_push_o with tx_data_o/tx_strb_o, resp OKAY; else → WR_WAIT_TX.
  - Non-TX-wait cases → WR_RESP.
- WR_WAIT_TX:
  - !tx_full_i: push, OKAY → WR_RESP.
  - Otherwise increment the counter; when counter == TX_WAIT, SLVERR without push → WR_RESP.
  - TX_WAIT = 0 gives SLVERR on the first full cycle.
- RD_EXEC:
  - sel 0/1/2: return the corresponding register with OKAY.
  - sel 3: if !rx_empty_i, return rx_data_i with OKAY and pulse rx_pull_o; else → RD_WAIT_RX.
- RD_WAIT_RX: same bounded wait as WR_WAIT_TX. On timeout, data = all ones, SLVERR.
- WR_RESP / RD_RESP:
  - Hold until the response FIFO is not full, then pulse the push for one cycle with stable data → IDLE.
  - Minimum transaction time is 3 cycles plus waits. The next grant can occur in the cycle after the push.
- Start control:
  - A rising edge on reg_trans_ctrl_i[START_BIT] (previous-value register) with spi_busy_o = 0 pulses trans_start_o one cycle later.
  - A rising edge while busy pulses start_err_o instead; no start is issued.
  - spi_busy_o sets on trans_start_o and clears on trans_done_i. If both occur in the same cycle, set wins.
- Counter width is clog2(max(TX_WAIT, RX_WAIT) + 1). The counter clears on every state entry.

Decomposition:
- Package fifo2spi_pkg: resp codes, sel codes (SEL_CTRL, SEL_TCTRL, SEL_STATUS, SEL_FIFO), FSM state encoding, and a strobe-merge function.
- Sub-module spi_start_ctrl: edge detect, busy flag, start_err.

Test Plan:
- Simultaneous write (sel 1, data 0xA5A5_0000, strb 4'b1100) and read (sel 2) pending after reset → write granted first. reg_load_o occurs with reg_data_o = {0xA5A5, low 16 bits of reg_trans_ctrl_i}, then the read is serviced; wr_resp 00.
- Continuous write and read streams → grants alternate W,R,W,R. No path waits more than one transaction.
- TX write with tx_full_i held high, TX_WAIT = 16 → no tx_push_o, wr_resp = 2'b10 after 16 wait cycles. Repeat with full released at cycle 5 → push occurs, resp 00.
- RX read with rx_empty_i high for > RX_WAIT cycles → rd_resp_data_o = {32'hFFFF_FFFF, 2'b10}. Write to sel 2 → SLVERR, no reg_load_o.
- wr_resp_full_i high for 10 cycles → wr_resp_push_o withheld, then a single pulse. Reset asserted during WR_RESP → no push, all outputs 0.
- START_BIT toggles 0→1 → trans_start_o one pulse, spi_busy_o = 1. A second edge before trans_done_i → start_err_o pulse, no start. trans_done_i → busy clears.

Source files
------------

// File: rtl/fifo2spi_pkg.sv
// Shared codes, FSM state encoding and the byte strobe-merge helper for the
// AXI-FIFO to SPI-register request decoder.
package fifo2spi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_TCTRL  = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_FIFO   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EXEC,
    ST_WR_WAIT_TX,
    ST_WR_RESP,
    ST_RD_EXEC,
    ST_RD_WAIT_RX,
    ST_RD_RESP
  } state_t;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  // One byte lane of a read-modify-write: strobed lanes take the new data.
  function automatic logic [7:0] strb_merge(input logic [7:0] wbyte,
                                            input logic [7:0] cbyte,
                                            input logic       strb);
    return strb ? wbyte : cbyte;
  endfunction

endpackage

// File: rtl/fifo2spi_arb_start.sv
// Start-pulse generator: rising-edge detect on the start bit, busy tracking
// and collision flagging when a start arrives while a transfer is running.
module spi_start_ctrl (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_bit,
  input  logic trans_done,
  output logic trans_start,
  output logic spi_busy,
  output logic start_err
);

  logic start_prev;
  logic start_rise;

  assign start_rise = start_bit & ~start_prev;

  // Setting busy takes priority over a concurrent done.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_prev  <= 1'b0;
      trans_start <= 1'b0;
      start_err   <= 1'b0;
      spi_busy    <= 1'b0;
    end else begin
      start_prev  <= start_bit;
      trans_start <= start_rise & ~spi_busy;
      start_err   <= start_rise & spi_busy;
      if (start_rise & ~spi_busy)
        spi_busy <= 1'b1;
      else if (trans_done)
        spi_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo2spi_arb.sv
// Request decoder between AXI-side request/data/response FIFOs and the SPI-side
// register file and TX/RX FIFOs, with round-robin read/write arbitration.
module fifo2spi_arb
  import fifo2spi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int STRB_W    = DATA_W / 8,
  parameter int START_BIT = 13,
  parameter int TX_WAIT   = 16,
  parameter int RX_WAIT   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [DATA_W-1:0]        reg_control_i,
  input  logic [DATA_W-1:0]        reg_trans_ctrl_i,
  input  logic [DATA_W-1:0]        reg_status_i,
  output logic [DATA_W-1:0]        reg_data_o,
  output logic                     reg_load_o,
  output logic [1:0]               reg_sel_o,
  input  logic                     wr_req_empty_i,
  input  logic                     wr_data_empty_i,
  input  logic [1:0]               wr_req_data_i,
  input  logic [DATA_W+STRB_W-1:0] wr_data_data_i,
  output logic                     wr_req_pull_o,
  output logic                     wr_data_pull_o,
  input  logic                     wr_resp_full_i,
  output logic [1:0]               wr_resp_data_o,
  output logic                     wr_resp_push_o,
  input  logic                     rd_req_empty_i,
  input  logic [1:0]               rd_req_data_i,
  output logic                     rd_req_pull_o,
  input  logic                     rd_resp_full_i,
  output logic [DATA_W+1:0]        rd_resp_data_o,
  output logic                     rd_resp_push_o,
  input  logic                     tx_full_i,
  output logic [DATA_W-1:0]        tx_data_o,
  output logic [STRB_W-1:0]        tx_strb_o,
  output logic                     tx_push_o,
  input  logic                     rx_empty_i,
  input  logic [DATA_W-1:0]        rx_data_i,
  output logic                     rx_pull_o,
  input  logic                     trans_done_i,
  output logic                     trans_start_o,
  output logic                     spi_busy_o,
  output logic                     start_err_o
);

  localparam int MAX_WAIT = (TX_WAIT > RX_WAIT) ? TX_WAIT : RX_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t              state, state_nxt;
  grant_t              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [1:0]          hold_sel, hold_sel_nxt;
  logic [DATA_W-1:0]   hold_data, hold_data_nxt;
  logic [STRB_W-1:0]   hold_strb, hold_strb_nxt;

  logic [DATA_W-1:0]   reg_data_nxt, tx_data_nxt;
  logic [STRB_W-1:0]   tx_strb_nxt;
  logic [1:0]          reg_sel_nxt, wr_resp_data_nxt;
  logic [DATA_W+1:0]   rd_resp_data_nxt;
  logic                reg_load_nxt, wr_req_pull_nxt, wr_data_pull_nxt, wr_resp_push_nxt;
  logic                rd_req_pull_nxt, rd_resp_push_nxt, tx_push_nxt, rx_pull_nxt;

  logic                wr_pend, rd_pend;
  logic [DATA_W-1:0]   cur_reg, merged;

  assign wr_pend = ~wr_req_empty_i & ~wr_data_empty_i;
  assign rd_pend = ~rd_req_empty_i;
  assign cur_reg = (hold_sel == SEL_CTRL) ? reg_control_i : reg_trans_ctrl_i;

  always_comb begin
    merged = '0;
    for (int b = 0; b < STRB_W; b++)
      merged[b*8 +: 8] = strb_merge(hold_data[b*8 +: 8], cur_reg[b*8 +: 8], hold_strb[b]);
  end

  // Data outputs hold their last value so responses stay stable while waiting.
  always_comb begin
    state_nxt        = state;
    last_grant_nxt   = last_grant;
    cnt_nxt          = '0;
    hold_sel_nxt     = hold_sel;
    hold_data_nxt    = hold_data;
    hold_strb_nxt    = hold_strb;
    reg_data_nxt     = reg_data_o;
    reg_sel_nxt      = reg_sel_o;
    reg_load_nxt     = 1'b0;
    wr_req_pull_nxt  = 1'b0;
    wr_data_pull_nxt = 1'b0;
    wr_resp_data_nxt = wr_resp_data_o;
    wr_resp_push_nxt = 1'b0;
    rd_req_pull_nxt  = 1'b0;
    rd_resp_data_nxt = rd_resp_data_o;
    rd_resp_push_nxt = 1'b0;
    tx_data_nxt      = tx_data_o;
    tx_strb_nxt      = tx_strb_o;
    tx_push_nxt      = 1'b0;
    rx_pull_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (wr_pend && (!rd_pend || last_grant == GRANT_READ)) begin
          hold_sel_nxt     = wr_req_data_i;
          hold_data_nxt    = wr_data_data_i[DATA_W+STRB_W-1:STRB_W];
          hold_strb_nxt    = wr_data_data_i[STRB_W-1:0];
          wr_req_pull_nxt  = 1'b1;
          wr_data_pull_nxt = 1'b1;
          last_grant_nxt   = GRANT_WRITE;
          state_nxt        = ST_WR_EXEC;
        end else if (rd_pend) begin
          hold_sel_nxt    = rd_req_data_i;
          rd_req_pull_nxt = 1'b1;
          last_grant_nxt  = GRANT_READ;
          state_nxt       = ST_RD_EXEC;
        end
      end

      ST_WR_EXEC: begin
        state_nxt = ST_WR_RESP;
        case (hold_sel)
          SEL_CTRL, SEL_TCTRL: begin
            reg_data_nxt     = merged;
            reg_sel_nxt      = hold_sel;
            reg_load_nxt     = |hold_strb;
            wr_resp_data_nxt = RESP_OKAY;
          end
          SEL_STATUS: wr_resp_data_nxt = RESP_SLVERR;
          default: begin
            if (!tx_full_i) begin
              tx_data_nxt      = hold_data;
              tx_strb_nxt      = hold_strb;
              tx_push_nxt      = 1'b1;
              wr_resp_data_nxt = RESP_OKAY;
            end else if (TX_WAIT == 0) begin
              wr_resp_data_nxt = RESP_SLVERR;
            end else begin
              state_nxt = ST_WR_WAIT_TX;
            end
          end
        endcase
      end

      ST_WR_WAIT_TX: begin
        if (!tx_full_i) begin
          tx_data_nxt      = hold_data;
          tx_strb_nxt      = hold_strb;
          tx_push_nxt      = 1'b1;
          wr_resp_data_nxt = RESP_OKAY;
          state_nxt        = ST_WR_RESP;
        end else if (cnt == CNT_W'(TX_WAIT)) begin
          wr_resp_data_nxt = RESP_SLVERR;
          state_nxt        = ST_WR_RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_WR_RESP: begin
        if (!wr_resp_full_i) begin
          wr_resp_push_nxt = 1'b1;
          state_nxt        = ST_IDLE;
        end
      end

      ST_RD_EXEC: begin
        state_nxt = ST_RD_RESP;
        case (hold_sel)
          SEL_CTRL:   rd_resp_data_nxt = {reg_control_i, RESP_OKAY};
          SEL_TCTRL:  rd_resp_data_nxt = {reg_trans_ctrl_i, RESP_OKAY};
          SEL_STATUS: rd_resp_data_nxt = {reg_status_i, RESP_OKAY};
          default: begin
            if (!rx_empty_i) begin
              rd_resp_data_nxt = {rx_data_i, RESP_OKAY};
              rx_pull_nxt      = 1'b1;
            end else if (RX_WAIT == 0) begin
              rd_resp_data_nxt = {{DATA_W{1'b1}}, RESP_SLVERR};
            end else begin
              state_nxt = ST_RD_WAIT_RX;
            end
          end
        endcase
      end

      ST_RD_WAIT_RX: begin
        if (!rx_empty_i) begin
          rd_resp_data_nxt = {rx_data_i, RESP_OKAY};
          rx_pull_nxt      = 1'b1;
          state_nxt        = ST_RD_RESP;
        end else if (cnt == CNT_W'(RX_WAIT)) begin
          rd_resp_data_nxt = {{DATA_W{1'b1}}, RESP_SLVERR};
          state_nxt        = ST_RD_RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_RD_RESP: begin
        if (!rd_resp_full_i) begin
          rd_resp_push_nxt = 1'b1;
          state_nxt        = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= ST_IDLE;
      last_grant     <= GRANT_READ;
      cnt            <= '0;
      hold_sel       <= '0;
      hold_data      <= '0;
      hold_strb      <= '0;
      reg_data_o     <= '0;
      reg_sel_o      <= '0;
      reg_load_o     <= 1'b0;
      wr_req_pull_o  <= 1'b0;
      wr_data_pull_o <= 1'b0;
      wr_resp_data_o <= '0;
      wr_resp_push_o <= 1'b0;
      rd_req_pull_o  <= 1'b0;
      rd_resp_data_o <= '0;
      rd_resp_push_o <= 1'b0;
      tx_data_o      <= '0;
      tx_strb_o      <= '0;
      tx_push_o      <= 1'b0;
      rx_pull_o      <= 1'b0;
    end else begin
      state          <= state_nxt;
      last_grant     <= last_grant_nxt;
      cnt            <= cnt_nxt;
      hold_sel       <= hold_sel_nxt;
      hold_data      <= hold_data_nxt;
      hold_strb      <= hold_strb_nxt;
      reg_data_o     <= reg_data_nxt;
      reg_sel_o      <= reg_sel_nxt;
      reg_load_o     <= reg_load_nxt;
      wr_req_pull_o  <= wr_req_pull_nxt;
      wr_data_pull_o <= wr_data_pull_nxt;
      wr_resp_data_o <= wr_resp_data_nxt;
      wr_resp_push_o <= wr_resp_push_nxt;
      rd_req_pull_o  <= rd_req_pull_nxt;
      rd_resp_data_o <= rd_resp_data_nxt;
      rd_resp_push_o <= rd_resp_push_nxt;
      tx_data_o      <= tx_data_nxt;
      tx_strb_o      <= tx_strb_nxt;
      tx_push_o      <= tx_push_nxt;
      rx_pull_o      <= rx_pull_nxt;
    end
  end

  spi_start_ctrl u_start (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .start_bit   (reg_trans_ctrl_i[START_BIT]),
    .trans_done  (trans_done_i),
    .trans_start (trans_start_o),
    .spi_busy    (spi_busy_o),
    .start_err   (start_err_o)
  );

endmodule

// File: tb/tb_fifo2spi_arb.sv
// Self-checking bench for fifo2spi_arb: emulates the surrounding FIFOs with
// queues and compares logged DUT activity against a transaction-level model.
module tb_fifo2spi_arb;

  localparam int DW      = 32;
  localparam int SW      = 4;
  localparam int TX_WAIT = 16;
  localparam int RX_WAIT = 16;
  localparam int N       = 12;

  logic           clk_i, reset_n_i;
  logic [DW-1:0]  reg_control_i, reg_trans_ctrl_i, reg_status_i;
  logic [DW-1:0]  reg_data_o;
  logic           reg_load_o;
  logic [1:0]     reg_sel_o;
  logic           wr_req_empty_i, wr_data_empty_i;
  logic [1:0]     wr_req_data_i;
  logic [DW+SW-1:0] wr_data_data_i;
  logic           wr_req_pull_o, wr_data_pull_o;
  logic           wr_resp_full_i;
  logic [1:0]     wr_resp_data_o;
  logic           wr_resp_push_o;
  logic           rd_req_empty_i;
  logic [1:0]     rd_req_data_i;
  logic           rd_req_pull_o;
  logic           rd_resp_full_i;
  logic [DW+1:0]  rd_resp_data_o;
  logic           rd_resp_push_o;
  logic           tx_full_i;
  logic [DW-1:0]  tx_data_o;
  logic [SW-1:0]  tx_strb_o;
  logic           tx_push_o;
  logic           rx_empty_i;
  logic [DW-1:0]  rx_data_i;
  logic           rx_pull_o;
  logic           trans_done_i, trans_start_o, spi_busy_o, start_err_o;

  fifo2spi_arb #(.DATA_W(DW), .STRB_W(SW), .START_BIT(13),
                 .TX_WAIT(TX_WAIT), .RX_WAIT(RX_WAIT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .reg_control_i(reg_control_i), .reg_trans_ctrl_i(reg_trans_ctrl_i),
    .reg_status_i(reg_status_i), .reg_data_o(reg_data_o),
    .reg_load_o(reg_load_o), .reg_sel_o(reg_sel_o),
    .wr_req_empty_i(wr_req_empty_i), .wr_data_empty_i(wr_data_empty_i),
    .wr_req_data_i(wr_req_data_i), .wr_data_data_i(wr_data_data_i),
    .wr_req_pull_o(wr_req_pull_o), .wr_data_pull_o(wr_data_pull_o),
    .wr_resp_full_i(wr_resp_full_i), .wr_resp_data_o(wr_resp_data_o),
    .wr_resp_push_o(wr_resp_push_o),
    .rd_req_empty_i(rd_req_empty_i), .rd_req_data_i(rd_req_data_i),
    .rd_req_pull_o(rd_req_pull_o),
    .rd_resp_full_i(rd_resp_full_i), .rd_resp_data_o(rd_resp_data_o),
    .rd_resp_push_o(rd_resp_push_o),
    .tx_full_i(tx_full_i), .tx_data_o(tx_data_o), .tx_strb_o(tx_strb_o),
    .tx_push_o(tx_push_o),
    .rx_empty_i(rx_empty_i), .rx_data_i(rx_data_i), .rx_pull_o(rx_pull_o),
    .trans_done_i(trans_done_i), .trans_start_o(trans_start_o),
    .spi_busy_o(spi_busy_o), .start_err_o(start_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int wr_pull_cyc = 0;
  int wr_push_cyc = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic force_tx_full = 1'b0;
  logic force_wr_full = 1'b0;

  logic [1:0]       wr_req_q[$];
  logic [DW+SW-1:0] wr_data_q[$];
  logic [1:0]       rd_req_q[$];
  logic [DW-1:0]    rx_q[$];
  logic [63:0]      grant_log[$], load_log[$], tx_log[$], wr_resp_log[$], rd_resp_log[$];
  logic [63:0]      exp_load[$], exp_tx[$], exp_wr[$], exp_rd[$];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    wr_req_empty_i  = (wr_req_q.size() == 0);
    wr_req_data_i   = wr_req_empty_i ? 2'd0 : wr_req_q[0];
    wr_data_empty_i = (wr_data_q.size() == 0);
    wr_data_data_i  = wr_data_empty_i ? '0 : wr_data_q[0];
    rd_req_empty_i  = (rd_req_q.size() == 0);
    rd_req_data_i   = rd_req_empty_i ? 2'd0 : rd_req_q[0];
    rx_empty_i      = (rx_q.size() == 0);
    rx_data_i       = rx_empty_i ? '0 : rx_q[0];
    tx_full_i       = force_tx_full;
    wr_resp_full_i  = force_wr_full;
    rd_resp_full_i  = 1'b0;
  endtask

  // Mid-cycle observation: log pulses, pop the emulated FIFOs, refresh heads.
  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if (wr_req_pull_o) begin
      grant_log.push_back(64'd1);
      wr_pull_cyc = cyc;
      if (wr_req_q.size() != 0) void'(wr_req_q.pop_front());
    end
    if (wr_data_pull_o && wr_data_q.size() != 0) void'(wr_data_q.pop_front());
    if (rd_req_pull_o) begin
      grant_log.push_back(64'd0);
      if (rd_req_q.size() != 0) void'(rd_req_q.pop_front());
    end
    if (rx_pull_o && rx_q.size() != 0) void'(rx_q.pop_front());
    if (tx_push_o)  tx_log.push_back(64'({tx_data_o, tx_strb_o}));
    if (reg_load_o) load_log.push_back(64'({reg_sel_o, reg_data_o}));
    if (wr_resp_push_o) begin
      wr_resp_log.push_back(64'(wr_resp_data_o));
      wr_push_cyc = cyc;
    end
    if (rd_resp_push_o) rd_resp_log.push_back(64'(rd_resp_data_o));
    if (trans_start_o) start_cnt++;
    if (start_err_o)   err_cnt++;
    drive_inputs();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_resp(input int nw, input int nr, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wr_resp_log.size() >= nw && rd_resp_log.size() >= nr) break;
      tick();
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (grant_log.size() >= n) break;
      tick();
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); load_log.delete(); tx_log.delete();
    wr_resp_log.delete(); rd_resp_log.delete();
    exp_load.delete(); exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic apply_stimulus(input logic is_wr, input logic [1:0] sel,
                                input logic [DW-1:0] data, input logic [SW-1:0] strb);
    if (is_wr) begin
      wr_req_q.push_back(sel);
      wr_data_q.push_back({data, strb});
    end else begin
      rd_req_q.push_back(sel);
    end
    drive_inputs();
  endtask

  function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] w, input logic [DW-1:0] c,
                                                input logic [SW-1:0] s);
    logic [DW-1:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (w & mask) | (c & ~mask);
  endfunction

  // Expected effects of one write, from the register-map rules.
  task automatic model_write(input logic [1:0] sel, input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (sel == 2'd0 || sel == 2'd1) begin
      if (s != 0) exp_load.push_back(64'({sel, model_merge(d, (sel == 2'd0) ? reg_control_i : reg_trans_ctrl_i, s)}));
      exp_wr.push_back(64'd0);
    end else if (sel == 2'd2) begin
      exp_wr.push_back(64'd2);
    end else begin
      exp_tx.push_back(64'({d, s}));
      exp_wr.push_back(64'd0);
    end
  endtask

  logic [DW-1:0] rx_exp[$];

  task automatic model_read(input logic [1:0] sel);
    case (sel)
      2'd0: exp_rd.push_back(64'({reg_control_i, 2'b00}));
      2'd1: exp_rd.push_back(64'({reg_trans_ctrl_i, 2'b00}));
      2'd2: exp_rd.push_back(64'({reg_status_i, 2'b00}));
      default: exp_rd.push_back(64'({rx_exp.pop_front(), 2'b00}));
    endcase
  endtask

  task automatic compare_logs(input string tag);
    check_output({tag, "_load_n"}, 64'(load_log.size()), 64'(exp_load.size()));
    for (int i = 0; i < load_log.size() && i < exp_load.size(); i++)
      check_output({tag, "_load"}, load_log[i], exp_load[i]);
    check_output({tag, "_tx_n"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      check_output({tag, "_tx"}, tx_log[i], exp_tx[i]);
    check_output({tag, "_wr_n"}, 64'(wr_resp_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_resp_log.size() && i < exp_wr.size(); i++)
      check_output({tag, "_wr_resp"}, wr_resp_log[i], exp_wr[i]);
    check_output({tag, "_rd_n"}, 64'(rd_resp_log.size()), 64'(exp_rd.size()));
    for (int i = 0; i < rd_resp_log.size() && i < exp_rd.size(); i++)
      check_output({tag, "_rd_resp"}, rd_resp_log[i], exp_rd[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, {reg_data_o, tx_data_o}, 64'd0);
    check_output({tag, "_rd_data"}, 64'(rd_resp_data_o), 64'd0);
    check_output({tag, "_ctrl"}, 64'({reg_load_o, reg_sel_o, wr_req_pull_o, wr_data_pull_o,
                  wr_resp_data_o, wr_resp_push_o, rd_req_pull_o, rd_resp_push_o, tx_strb_o,
                  tx_push_o, rx_pull_o, trans_start_o, spi_busy_o, start_err_o}), 64'd0);
  endtask

  initial begin
    logic [1:0]    sel;
    logic [DW-1:0] d;
    logic [SW-1:0] s;

    reset_n_i        = 1'b0;
    trans_done_i     = 1'b0;
    reg_control_i    = $urandom;
    reg_trans_ctrl_i = $urandom & ~(32'd1 << 13);
    reg_status_i     = $urandom;
    drive_inputs();
    wait_cycles(3);
    check_all_zero("reset");
    reset_n_i = 1'b1;
    wait_cycles(2);

    // Simultaneous write and read after reset: write wins the first grant.
    clear_logs();
    apply_stimulus(1'b1, 2'd1, 32'hA5A5_0000, 4'b1100);
    apply_stimulus(1'b0, 2'd2, '0, '0);
    exp_load.push_back(64'({2'd1, 16'hA5A5, reg_trans_ctrl_i[15:0]}));
    exp_wr.push_back(64'd0);
    exp_rd.push_back(64'({reg_status_i, 2'b00}));
    wait_resp(1, 1, 100);
    check_output("first_grant_w", grant_log.size() > 0 ? grant_log[0] : 64'hDEAD, 64'd1);
    check_output("second_grant_r", grant_log.size() > 1 ? grant_log[1] : 64'hDEAD, 64'd0);
    compare_logs("first");

    // Random concurrent write/read streams must alternate grants.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      d = $urandom;
      rx_q.push_back(d);
      rx_exp.push_back(d);
    end
    for (int i = 0; i < N; i++) begin
      sel = 2'($urandom_range(0, 3));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      apply_stimulus(1'b1, sel, d, s);
      model_write(sel, d, s);
      sel = 2'($urandom_range(0, 3));
      apply_stimulus(1'b0, sel, '0, '0);
      model_read(sel);
    end
    wait_resp(N, N, 2000);
    check_output("stream_grants_n", 64'(grant_log.size()), 64'(2 * N));
    for (int i = 0; i < grant_log.size(); i++)
      check_output("stream_alternate", grant_log[i], (i % 2 == 0) ? 64'd1 : 64'd0);
    compare_logs("stream");
    rx_q.delete();
    rx_exp.delete();
    drive_inputs();

    // TX held full for the whole bounded wait: SLVERR, no push.
    clear_logs();
    force_tx_full = 1'b1;
    d = $urandom;
    apply_stimulus(1'b1, 2'd3, d, 4'hF);
    exp_wr.push_back(64'd2);
    wait_resp(1, 0, 200);
    compare_logs("tx_timeout");
    check_output("tx_wait_len", 64'((wr_push_cyc - wr_pull_cyc) >= TX_WAIT + 2 &&
                                    (wr_push_cyc - wr_pull_cyc) <= TX_WAIT + 4), 64'd1);

    // TX full released part-way through the wait: push then OKAY.
    clear_logs();
    d = $urandom;
    s = 4'($urandom_range(1, 15));
    apply_stimulus(1'b1, 2'd3, d, s);
    exp_tx.push_back(64'({d, s}));
    exp_wr.push_back(64'd0);
    wait_grants(1, 50);
    wait_cycles(5);
    force_tx_full = 1'b0;
    drive_inputs();
    wait_resp(1, 0, 100);
    compare_logs("tx_release");

    // RX empty beyond the wait, then a write to the read-only status register.
    clear_logs();
    apply_stimulus(1'b0, 2'd3, '0, '0);
    exp_rd.push_back(64'({32'hFFFF_FFFF, 2'b10}));
    wait_resp(0, 1, 200);
    apply_stimulus(1'b1, 2'd2, $urandom, 4'hF);
    exp_wr.push_back(64'd2);
    wait_resp(1, 1, 100);
    compare_logs("rx_timeout_status");

    // Write response FIFO full for 10 cycles: push withheld, then exactly one.
    clear_logs();
    force_wr_full = 1'b1;
    d = $urandom;
    apply_stimulus(1'b1, 2'd0, d, 4'hF);
    exp_load.push_back(64'({2'd0, d}));
    exp_wr.push_back(64'd0);
    wait_grants(1, 50);
    wait_cycles(10);
    check_output("resp_withheld", 64'(wr_resp_log.size()), 64'd0);
    force_wr_full = 1'b0;
    drive_inputs();
    wait_cycles(8);
    compare_logs("resp_full");

    // Reset while parked in the response state abandons the transaction.
    clear_logs();
    force_wr_full = 1'b1;
    apply_stimulus(1'b1, 2'd1, $urandom, 4'h3);
    wait_grants(1, 50);
    wait_cycles(4);
    reset_n_i = 1'b0;
    #1;
    check_all_zero("mid_reset");
    wait_cycles(2);
    force_wr_full = 1'b0;
    reg_trans_ctrl_i = reg_trans_ctrl_i & ~(32'd1 << 13);
    drive_inputs();
    reset_n_i = 1'b1;
    wait_cycles(10);
    check_output("mid_reset_no_push", 64'(wr_resp_log.size()), 64'd0);

    // Start control: start, collision while busy, done clears busy.
    start_cnt = 0;
    err_cnt   = 0;
    reg_trans_ctrl_i[13] = 1'b1;
    wait_cycles(3);
    check_output("start_pulse", 64'(start_cnt), 64'd1);
    check_output("busy_set", 64'(spi_busy_o), 64'd1);
    reg_trans_ctrl_i[13] = 1'b0;
    wait_cycles(2);
    reg_trans_ctrl_i[13] = 1'b1;
    wait_cycles(3);
    check_output("start_err", 64'(err_cnt), 64'd1);
    check_output("no_second_start", 64'(start_cnt), 64'd1);
    trans_done_i = 1'b1;
    tick();
    trans_done_i = 1'b0;
    wait_cycles(2);
    check_output("busy_clear", 64'(spi_busy_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
